// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing generator and pixel output stage.
// Ports:
//   clk_fpga              pixel clock
//   rst                   synchronous reset, active-high
//   x, y                  active-area coordinates (0 outside the active area)
//   pix_req               counters are at an active pixel
//   frame_start           counters are at h=0, v=0
//   rgb_in                pixel {R,G,B} from the source, PIX_LAT cycles after pix_req
//   vga_hs, vga_vs        registered syncs
//   vga_de                registered data enable
//   vga_data              registered expanded colour {R,G,B}
// Optional feature macro: VGA_BORDER_EN forces the outermost active pixels to white.
module vga_timing_gen #(
    parameter int H_ACT    = 800,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 80,
    parameter int H_BACK   = 160,
    parameter int V_ACT    = 600,
    parameter int V_FRONT  = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 21,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int IN_BITS  = 2,
    parameter int OUT_BITS = 4,
    parameter int PIX_LAT  = 1
) (
    input  logic                    clk_fpga,
    input  logic                    rst,
    output logic [11:0]             x,
    output logic [11:0]             y,
    output logic                    pix_req,
    output logic                    frame_start,
    input  logic [3*IN_BITS-1:0]    rgb_in,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_de,
    output logic [3*OUT_BITS-1:0]   vga_data
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam logic [11:0] HT_M1 = 12'(H_BLANK + H_ACT - 1);
    localparam logic [11:0] VT_M1 = 12'(V_BLANK + V_ACT - 1);
    localparam logic [11:0] HB    = 12'(H_BLANK);
    localparam logic [11:0] VB    = 12'(V_BLANK);
    localparam logic [11:0] HS0   = 12'(H_FRONT);
    localparam logic [11:0] HS1   = 12'(H_FRONT + H_SYNC);
    localparam logic [11:0] VS0   = 12'(V_FRONT);
    localparam logic [11:0] VS1   = 12'(V_FRONT + V_SYNC);
    localparam logic HS_LVL = 1'(HS_POL);
    localparam logic VS_LVL = 1'(VS_POL);
`ifdef VGA_BORDER_EN
    localparam int DW = 4;
    localparam logic [11:0] HA_M1 = 12'(H_ACT - 1);
    localparam logic [11:0] VA_M1 = 12'(V_ACT - 1);
`else
    localparam int DW = 3;
`endif

    logic [11:0] h_count, v_count;
    logic hs_raw, vs_raw;
    logic [DW-1:0] raw, dly;
    logic [3*OUT_BITS-1:0] exp_rgb, pix;

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == HT_M1) begin
            h_count <= '0;
            v_count <= (v_count == VT_M1) ? '0 : v_count + 12'd1;
        end else begin
            h_count <= h_count + 12'd1;
        end
    end

    assign hs_raw      = h_count >= HS0 && h_count < HS1;
    assign vs_raw      = v_count >= VS0 && v_count < VS1;
    assign pix_req     = h_count >= HB && v_count >= VB;
    assign x           = pix_req ? h_count - HB : '0;
    assign y           = pix_req ? v_count - VB : '0;
    assign frame_start = h_count == '0 && v_count == '0;

    // Each output bit j (counted from the channel MSB) takes input bit j mod IN_BITS,
    // which both truncates (OUT<=IN) and replicates MSB-first (OUT>IN).
    for (genvar c = 0; c < 3; c++) begin : g_ch
        for (genvar j = 0; j < OUT_BITS; j++) begin : g_bit
            assign exp_rgb[c*OUT_BITS + OUT_BITS-1-j] = rgb_in[c*IN_BITS + IN_BITS-1-(j % IN_BITS)];
        end
    end

`ifdef VGA_BORDER_EN
    logic border_raw;
    assign border_raw = pix_req && (x == '0 || x == HA_M1 || y == '0 || y == VA_M1);
    assign raw = {border_raw, pix_req, vs_raw, hs_raw};
    assign pix = dly[3] ? '1 : exp_rgb;
`else
    assign raw = {pix_req, vs_raw, hs_raw};
    assign pix = exp_rgb;
`endif

    // Control flags wait PIX_LAT cycles so they meet the rgb_in sample for the same pixel.
    if (PIX_LAT == 0) begin : g_nodly
        assign dly = raw;
    end else begin : g_dly
        logic [DW-1:0] sr [PIX_LAT];
        always_ff @(posedge clk_fpga) begin
            if (rst) begin
                sr <= '{default: '0};
            end else begin
                sr[0] <= raw;
                for (int i = 1; i < PIX_LAT; i++) sr[i] <= sr[i-1];
            end
        end
        assign dly = sr[PIX_LAT-1];
    end

    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            vga_hs   <= ~HS_LVL;
            vga_vs   <= ~VS_LVL;
            vga_de   <= 1'b0;
            vga_data <= '0;
        end else begin
            vga_hs   <= dly[0] ? HS_LVL : ~HS_LVL;
            vga_vs   <= dly[1] ? VS_LVL : ~VS_LVL;
            vga_de   <= dly[2];
            vga_data <= dly[2] ? pix : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized check of vga_timing_gen against a linear-position frame model.
module tb_vga_timing_gen;
    localparam int HA = 20, HF = 3, HSW = 4, HBK = 5;
    localparam int VA = 6, VF = 1, VSW = 2, VBK = 3;
    localparam int HSP = 1, VSP = 0, IN = 2, OUT = 4, LAT = 2;
    localparam int HB = HF + HSW + HBK, HT = HB + HA;
    localparam int VB = VF + VSW + VBK, VT = VB + VA;
    localparam int FT = HT * VT;
    localparam int MID = (VB + 3) * HT + HB + 10;
    localparam int NCYC = 12 * FT;

    logic clk_fpga = 1'b0;
    logic rst = 1'b1;
    logic [5:0] rgb_in = '0;
    logic [11:0] x, y, vga_data;
    logic pix_req, frame_start, vga_hs, vga_vs, vga_de;

    always #5 clk_fpga = ~clk_fpga;

    vga_timing_gen #(
        .H_ACT(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HBK),
        .V_ACT(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VBK),
        .HS_POL(HSP), .VS_POL(VSP), .IN_BITS(IN), .OUT_BITS(OUT), .PIX_LAT(LAT)
    ) dut (
        .clk_fpga(clk_fpga), .rst(rst), .x(x), .y(y), .pix_req(pix_req),
        .frame_start(frame_start), .rgb_in(rgb_in), .vga_hs(vga_hs),
        .vga_vs(vga_vs), .vga_de(vga_de), .vga_data(vga_data)
    );

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Repeat the channel value enough times, then keep the top OUT bits.
    function automatic logic [11:0] expand(input logic [5:0] v);
        logic [11:0] r = '0;
        for (int c = 0; c < 3; c++) begin
            int ch, copies, rep;
            ch = (int'(v) >> (c * IN)) & ((1 << IN) - 1);
            copies = (OUT + IN - 1) / IN;
            rep = 0;
            for (int k = 0; k < copies; k++) rep = (rep << IN) | ch;
            r |= 12'((rep >> (copies * IN - OUT)) << (c * OUT));
        end
        return r;
    endfunction

    // {border, de, vs, hs} as asserted flags for linear frame position n.
    function automatic logic [3:0] flags(input int n);
        int h, v;
        logic de, bd;
        h = n % HT;
        v = n / HT;
        de = h >= HB && v >= VB;
`ifdef VGA_BORDER_EN
        bd = de && (h == HB || h == HT - 1 || v == VB || v == VT - 1);
`else
        bd = 1'b0;
`endif
        return {bd, de, 1'(v >= VF && v < VF + VSW), 1'(h >= HF && h < HF + HSW)};
    endfunction

    logic [3:0] hist [16];
    logic [5:0] rgbh [16];
    logic [11:0] xh [16];

    initial begin
        int cnt, rst_hold;
        bit prev_rst, mid_done;
        logic [3:0] f, o;
        logic [5:0] rg;
        logic [11:0] ex;
        foreach (hist[i]) begin
            hist[i] = '0;
            rgbh[i] = '0;
            xh[i] = '0;
        end
        repeat (3) @(posedge clk_fpga);
        @(negedge clk_fpga);
        check("rst_hs", vga_hs, 32'(1 - HSP));
        check("rst_vs", vga_vs, 32'(1 - VSP));
        check("rst_de", vga_de, 0);
        check("rst_data", vga_data, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_req", pix_req, 0);
        check("rst_fs", frame_start, 1);
        prev_rst = 1'b1;
        cnt = 0;
        rst_hold = 0;
        mid_done = 1'b0;
        for (int cyc = 100; cyc < 100 + NCYC; cyc++) begin
            @(negedge clk_fpga);
            cnt = prev_rst ? 0 : (cnt + 1) % FT;
            f = flags(cnt);
            hist[cyc % 16] = f;
            xh[cyc % 16] = f[2] ? 12'(cnt % HT - HB) : 12'd0;
            check("x", x, 32'(xh[cyc % 16]));
            check("y", y, f[2] ? 32'(cnt / HT - VB) : 0);
            check("pix_req", pix_req, 32'(f[2]));
            check("frame_start", frame_start, 32'(cnt == 0));
            o = hist[(cyc - 1 - LAT) % 16];
            rg = rgbh[(cyc - 1) % 16];
            ex = o[2] ? (o[3] ? 12'hFFF : expand(rg)) : 12'h000;
            check("vga_hs", vga_hs, o[0] ? 32'(HSP) : 32'(1 - HSP));
            check("vga_vs", vga_vs, o[1] ? 32'(VSP) : 32'(1 - VSP));
            check("vga_de", vga_de, 32'(o[2]));
            check("vga_data", vga_data, 32'(ex));
            if (o[2] && !o[3] && rg == 6'b10_01_11) check("const_col", vga_data, 32'h0A5F);
            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else if (!mid_done && cyc > 4 * FT && cnt == MID) begin
                rst = 1'b1;
                rst_hold = 1;
                mid_done = 1'b1;
            end else if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b1;
                rst_hold = $urandom_range(0, 2);
            end else begin
                rst = 1'b0;
            end
            case ((cyc / FT) % 4)
                1: rgb_in = 6'b10_01_11;
                2: rgb_in = xh[(cyc - LAT) % 16][5:0];
                default: rgb_in = 6'($urandom);
            endcase
            rgbh[cyc % 16] = rgb_in;
            prev_rst = rst;
            if (rst) for (int i = 0; i <= LAT; i++) hist[(cyc - i) % 16] = '0;
        end
        if (!mid_done) check("mid_reset_reached", 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
